// File: rtl/q2_i2c_target.sv
// I2C target for the Q2 bus: 16 x 8-bit register file behind an auto-incrementing
// pointer. SCL/SDA are oversampled on clk; a START or STOP wins over an SCL edge.
module q2_i2c_target #(
  parameter logic [6:0] TADDR      = 7'h50,
  parameter logic [3:0] STATUS_REG = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic [7:0] ctrl,
  input  logic [7:0] status,
  output logic       wr_stb,
  output logic [3:0] wr_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK
  } state_t;

  state_t      state, state_n;
  logic [2:0]  scl_sr, sda_sr;
  logic [2:0]  cnt, cnt_n;
  logic        full, full_n;
  logic [7:0]  shreg, shreg_n;
  logic [3:0]  ptr, ptr_n;
  logic        rw, rw_n;
  logic        sda_oe_n, busy_n, wr_stb_n;
  logic [3:0]  wr_idx_n;
  logic        we;
  logic [7:0]  regs [16];
  logic [7:0]  rd_byte;
  logic        sda_s, rise, fall, start, stop;

  // Two sync flops plus one history flop per pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], scl};
      sda_sr <= {sda_sr[1:0], sda_in};
    end
  end

  assign sda_s   = sda_sr[1];
  assign rise    = scl_sr[1] & ~scl_sr[2];
  assign fall    = ~scl_sr[1] & scl_sr[2];
  assign start   = scl_sr[1] & scl_sr[2] & ~sda_sr[1] & sda_sr[2];
  assign stop    = scl_sr[1] & scl_sr[2] & sda_sr[1] & ~sda_sr[2];
  assign rd_byte = (ptr == STATUS_REG) ? status : regs[ptr];
  assign ctrl    = regs[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 3'd0;
      full   <= 1'b0;
      shreg  <= 8'd0;
      ptr    <= 4'd0;
      rw     <= 1'b0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
      wr_stb <= 1'b0;
      wr_idx <= 4'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      full   <= full_n;
      shreg  <= shreg_n;
      ptr    <= ptr_n;
      rw     <= rw_n;
      sda_oe <= sda_oe_n;
      busy   <= busy_n;
      wr_stb <= wr_stb_n;
      wr_idx <= wr_idx_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
    end else if (we) begin
      regs[ptr] <= shreg;
    end
  end

  // Bits are sampled on SCL rise; SDA is only driven/released on SCL fall
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    full_n   = full;
    shreg_n  = shreg;
    ptr_n    = ptr;
    rw_n     = rw;
    sda_oe_n = sda_oe;
    busy_n   = busy;
    wr_stb_n = 1'b0;
    wr_idx_n = wr_idx;
    we       = 1'b0;

    if (stop) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      cnt_n    = 3'd0;
      full_n   = 1'b0;
    end else if (start) begin
      state_n  = S_ADDR;
      sda_oe_n = 1'b0;
      cnt_n    = 3'd0;
      full_n   = 1'b0;
    end else if (rise) begin
      case (state)
        S_ADDR, S_PTR, S_WR: begin
          shreg_n = {shreg[6:0], sda_s};
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) full_n = 1'b1;
        end
        S_RD: begin
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) full_n = 1'b1;
        end
        S_RD_ACK: begin
          if (!sda_s) begin
            ptr_n  = ptr + 4'd1;
            full_n = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
        default: ;
      endcase
    end else if (fall) begin
      case (state)
        S_ADDR: begin
          if (full) begin
            cnt_n  = 3'd0;
            full_n = 1'b0;
            if (shreg[7:1] == TADDR) begin
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              rw_n     = shreg[0];
              state_n  = S_ADDR_ACK;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (rw) begin
            shreg_n  = rd_byte;
            sda_oe_n = ~rd_byte[7];
            state_n  = S_RD;
          end else begin
            sda_oe_n = 1'b0;
            state_n  = S_PTR;
          end
        end
        S_PTR: begin
          if (full) begin
            cnt_n    = 3'd0;
            full_n   = 1'b0;
            sda_oe_n = 1'b1;
            ptr_n    = shreg[3:0];
            state_n  = S_PTR_ACK;
          end
        end
        S_PTR_ACK, S_WR_ACK: begin
          sda_oe_n = 1'b0;
          state_n  = S_WR;
        end
        S_WR: begin
          if (full) begin
            cnt_n    = 3'd0;
            full_n   = 1'b0;
            sda_oe_n = 1'b1;
            we       = (ptr != STATUS_REG);
            wr_stb_n = (ptr != STATUS_REG);
            wr_idx_n = ptr;
            ptr_n    = ptr + 4'd1;
            state_n  = S_WR_ACK;
          end
        end
        S_RD: begin
          if (full) begin
            cnt_n    = 3'd0;
            full_n   = 1'b0;
            sda_oe_n = 1'b0;
            state_n  = S_RD_ACK;
          end else begin
            sda_oe_n = ~shreg[3'd7 - cnt];
          end
        end
        S_RD_ACK: begin
          if (full) begin
            full_n   = 1'b0;
            shreg_n  = rd_byte;
            sda_oe_n = ~rd_byte[7];
            state_n  = S_RD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q2_i2c_target.sv
// Bench for q2_i2c_target: bit-banged I2C initiator on a wired-AND SDA, with
// queued expectations for register writes and read-back bytes.
module tb_q2_i2c_target;

  localparam int unsigned Q = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, busy, wr_stb;
  logic [7:0] ctrl;
  logic [7:0] status = 8'hC3;
  logic [3:0] wr_idx;

  int errors = 0;
  int checks = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [7:0] rd_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  q2_i2c_target dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe), .busy(busy),
    .ctrl(ctrl), .status(status), .wr_stb(wr_stb), .wr_idx(wr_idx)
  );

  always #5 clk = ~clk;

  // Pops one expected write per observed wr_stb pulse
  task automatic monitor();
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (wr_stb) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_stb_unexpected: got idx=%0d, required no strobe", wr_idx);
        end else begin
          e = wr_q.pop_front();
          if (wr_idx !== e.idx || (e.idx == 4'd0 && ctrl !== e.data)) begin
            errors++;
            $display("FAIL wr_stb_payload: got idx=%0d ctrl=%02h, required idx=%0d data=%02h",
                     wr_idx, ctrl, e.idx, e.data);
          end
        end
      end
    end
  endtask

  task automatic bit_out(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  // ack=1 only if the target holds SDA low across the whole 9th SCL high
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic a1, a2;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; a1 = sda_oe; #(Q-10); a2 = sda_oe; #10;
    scl = 1'b0; #Q;
    ack = a1 & a2;
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; d[i] = sda_bus; #Q; scl = 1'b0; #Q;
    end
    sda_m = ack_bit; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; sda_m = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b, required 0", sda_oe); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb: got %b, required 0", wr_stb); end
    if (wr_idx !== 4'd0) begin errors++; $display("FAIL reset_wr_idx: got %0d, required 0", wr_idx); end
    if (ctrl !== 8'h00)  begin errors++; $display("FAIL reset_ctrl: got %02h, required 00", ctrl); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_single();
    logic a0, a1, a2;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h00, a1);
    wr_q.push_back('{4'd0, 8'h5A});
    write_byte(8'h5A, a2);
    checks += 2;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL single_acks: got %b, required 111", {a0, a1, a2}); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b, required 1", busy); end
    i2c_stop();
    checks += 2;
    if (ctrl !== 8'h5A) begin errors++; $display("FAIL single_ctrl: got %02h, required 5A", ctrl); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL single_busy_stop: got %b, required 0", busy); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1, a2;
    int o0, b0;
    o0 = oe_cnt; b0 = busy_cnt;
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h00, a1);
    write_byte(8'h99, a2);
    i2c_stop();
    checks += 4;
    if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL mismatch_acks: got %b, required 000", {a0, a1, a2}); end
    if (oe_cnt != o0)   begin errors++; $display("FAIL mismatch_sda_oe: got %0d driven clks, required 0", oe_cnt - o0); end
    if (busy_cnt != b0) begin errors++; $display("FAIL mismatch_busy: got %0d busy clks, required 0", busy_cnt - b0); end
    if (ctrl !== 8'h5A) begin errors++; $display("FAIL mismatch_ctrl: got %02h, required 5A", ctrl); end
  endtask

  task automatic test_burst_wrap();
    logic [4:0] a;
    i2c_start();
    write_byte(8'hA0, a[0]);
    write_byte(8'h0E, a[1]);
    wr_q.push_back('{4'd14, 8'h11});
    write_byte(8'h11, a[2]);
    write_byte(8'h22, a[3]);
    wr_q.push_back('{4'd0, 8'h33});
    write_byte(8'h33, a[4]);
    i2c_stop();
    checks += 3;
    if (a !== 5'h1F) begin errors++; $display("FAIL burst_acks: got %b, required 11111", a); end
    if (ctrl !== 8'h33) begin errors++; $display("FAIL burst_ctrl: got %02h, required 33", ctrl); end
    if (wr_q.size() != 0) begin errors++; $display("FAIL burst_strobes: got %0d missing, required 0", wr_q.size()); end
  endtask

  task automatic test_repeated_start_read();
    logic [2:0] a;
    logic [7:0] d, e;
    i2c_start();
    write_byte(8'hA0, a[0]);
    write_byte(8'h0E, a[1]);
    i2c_start();
    write_byte(8'hA1, a[2]);
    rd_q.push_back(8'h11);
    rd_q.push_back(8'hC3);
    checks++;
    if (a !== 3'b111) begin errors++; $display("FAIL rd_acks: got %b, required 111", a); end
    for (int k = 0; k < 2; k++) begin
      read_byte(k == 1, d);
      e = rd_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL rd_byte%0d: got %02h, required %02h", k, d, e); end
    end
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release_after_nack: got %b, required 0", sda_oe); end
    i2c_stop();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_stop: got %b, required 0", busy); end
  endtask

  task automatic test_stop_in_byte();
    logic a0, a1;
    int o0;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h00, a1);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    i2c_stop();
    scl = 1'b0; #Q;
    o0 = oe_cnt;
    for (int i = 0; i < 9; i++) bit_out(1'b0);
    scl = 1'b1; #(2*Q);
    checks += 4;
    if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL stopbyte_acks: got %b, required 11", {a0, a1}); end
    if (ctrl !== 8'h33) begin errors++; $display("FAIL stopbyte_ctrl: got %02h, required 33", ctrl); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL stopbyte_busy: got %b, required 0", busy); end
    if (oe_cnt != o0)   begin errors++; $display("FAIL stopbyte_idle: got %0d driven clks, required 0", oe_cnt - o0); end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] a;
    i2c_start();
    write_byte(8'hA0, a[0]);
    write_byte(8'h00, a[1]);
    i2c_start();
    write_byte(8'hA1, a[2]);
    #20;
    checks += 2;
    if (a[2:0] !== 3'b111) begin errors++; $display("FAIL rstrd_acks: got %b, required 111", a[2:0]); end
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstrd_drive0: got %b, required 1", sda_oe); end
    rst = 1'b1;
    #1;
    checks += 3;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstrd_sda_oe: got %b, required 0", sda_oe); end
    if (ctrl !== 8'h00)  begin errors++; $display("FAIL rstrd_ctrl: got %02h, required 00", ctrl); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL rstrd_busy: got %b, required 0", busy); end
    #20;
    scl = 1'b1; sda_m = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0] a;
    i2c_start();
    write_byte(8'hA0, a[0]);
    write_byte(8'h00, a[1]);
    wr_q.push_back('{4'd0, 8'h7E});
    write_byte(8'h7E, a[2]);
    i2c_stop();
    checks += 2;
    if (a !== 3'b111) begin errors++; $display("FAIL b2b_acks: got %b, required 111", a); end
    if (ctrl !== 8'h7E) begin errors++; $display("FAIL b2b_ctrl: got %02h, required 7E", ctrl); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    @(negedge clk);
    test_reset();
    test_write_single();
    test_addr_mismatch();
    test_burst_wrap();
    test_repeated_start_read();
    test_stop_in_byte();
    test_reset_mid_read();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (wr_q.size() != 0) begin errors++; $display("FAIL strobes_missing: got %0d pending, required 0", wr_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
